// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the legal operand-width range.
package serial_adder_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full-adder slice used by the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per
// clock, LSB first; the result is published in a single-cycle DONE state.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SUB_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_adder: WIDTH out of legal range");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              sub_eff;
    logic              fa_s;
    logic              fa_co;

    assign sub_eff = sub & SUB_EN;

    fa_cell u_fa (
        .a  (a_q[cnt_q]),
        .b  (b_q[cnt_q]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + ~borrow, so cout reads as "no borrow".
                    a_d     = a;
                    b_d     = sub_eff ? ~b : b;
                    carry_d = sub_eff ? ~cin : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                carry_d = fa_co;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=16 with directed vectors.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s8_start, s8_sub, s8_cin;
    logic [7:0]  s8_a, s8_b;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        s16_start, s16_sub, s16_cin;
    logic [15:0] s16_a, s16_b;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    serial_adder #(.WIDTH(8), .SUB_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .sub(s8_sub),
        .a(s8_a), .b(s8_b), .cin(s8_cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(16), .SUB_EN(1'b1)) dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .sub(s16_sub),
        .a(s16_a), .b(s16_b), .cin(s16_cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    typedef struct {
        string       name;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t m8, m16;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: got done=1 expected no done at cyc %0d", cyc);
            end else begin
                m8 = q8.pop_front();
                chk({m8.name, "_sum"}, {56'd0, sum8}, {48'd0, m8.sum});
                chk({m8.name, "_cout"}, {63'd0, cout8}, {63'd0, m8.cout});
                chk({m8.name, "_ovf"}, {63'd0, ovf8}, {63'd0, m8.ovf});
                chk({m8.name, "_latency"}, 64'(cyc), 64'(m8.cyc));
                $display("txn w8  %s: sum=%h cout=%b ovf=%b cyc=%0d", m8.name, sum8, cout8, ovf8, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done16: got done=1 expected no done at cyc %0d", cyc);
            end else begin
                m16 = q16.pop_front();
                chk({m16.name, "_sum"}, {48'd0, sum16}, {48'd0, m16.sum});
                chk({m16.name, "_cout"}, {63'd0, cout16}, {63'd0, m16.cout});
                chk({m16.name, "_ovf"}, {63'd0, ovf16}, {63'd0, m16.ovf});
                chk({m16.name, "_latency"}, 64'(cyc), 64'(m16.cyc));
                $display("txn w16 %s: sum=%h cout=%b ovf=%b cyc=%0d", m16.name, sum16, cout16, ovf16, cyc);
            end
        end
    end

    // Issue one WIDTH=8 operation; returns #1 after the accepting edge.
    task automatic op8(input string name, input logic sb, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic push, input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        @(posedge clk); #1;
        s8_sub = sb; s8_a = ia; s8_b = ib; s8_cin = ic; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        if (push) begin
            e.name = name; e.sum = {8'd0, es}; e.cout = ec; e.ovf = eo; e.cyc = cyc + 8;
            q8.push_back(e);
        end
        chk({name, "_busy"}, {63'd0, busy8}, 64'd1);
    endtask

    task automatic op16(input string name, input logic sb, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        @(posedge clk); #1;
        s16_sub = sb; s16_a = ia; s16_b = ib; s16_cin = ic; s16_start = 1'b1;
        @(posedge clk); #1;
        s16_start = 1'b0;
        e.name = name; e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 16;
        q16.push_back(e);
        chk({name, "_busy"}, {63'd0, busy16}, 64'd1);
    endtask

    task automatic wait_done8(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_done16(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done16 === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        s8_start = 0; s8_sub = 0; s8_cin = 0; s8_a = 0; s8_b = 0;
        s16_start = 0; s16_sub = 0; s16_cin = 0; s16_a = 0; s16_b = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {63'd0, busy8}, 64'd0);
        chk("reset_done", {63'd0, done8}, 64'd0);
        chk("reset_sum", {56'd0, sum8}, 64'd0);
        chk("reset_cout", {63'd0, cout8}, 64'd0);
        chk("reset_ovf", {63'd0, ovf8}, 64'd0);

        op8("add_5a_33", 0, 8'h5A, 8'h33, 0, 1, 8'h8D, 0, 1); wait_done8("add_5a_33", 12);
        op8("add_ff_01", 0, 8'hFF, 8'h01, 1, 1, 8'h01, 1, 0); wait_done8("add_ff_01", 12);
        op8("sub_10_20", 1, 8'h10, 8'h20, 0, 1, 8'hF0, 0, 0); wait_done8("sub_10_20", 12);
        op8("sub_80_01", 1, 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1); wait_done8("sub_80_01", 12);

        // Start pulsed in RUN cycle 3 with different operands must be ignored.
        op8("ignore", 0, 8'h01, 8'h02, 0, 1, 8'h03, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        s8_a = 8'hFF; s8_b = 8'hFF; s8_sub = 1'b1; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        chk("ignore_sum_held", {56'd0, sum8}, 64'h7F);
        wait_done8("ignore", 12);

        // Start held through DONE: next operation accepted with no IDLE cycle.
        op8("b2b_first", 0, 8'h0F, 8'h01, 0, 1, 8'h10, 0, 0);
        wait_done8("b2b_first", 12);
        s8_sub = 1'b0; s8_a = 8'h12; s8_b = 8'h34; s8_cin = 1'b1; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        e.name = "b2b_second"; e.sum = 16'h0047; e.cout = 0; e.ovf = 0; e.cyc = cyc + 8;
        q8.push_back(e);
        chk("b2b_no_idle_busy", {63'd0, busy8}, 64'd1);
        wait_done8("b2b_second", 12);

        // Reset in RUN cycle 4 aborts; no done may follow.
        op8("abort", 0, 8'hAA, 8'h11, 0, 0, 8'h00, 0, 0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy8}, 64'd0);
        chk("abort_done", {63'd0, done8}, 64'd0);
        chk("abort_sum", {56'd0, sum8}, 64'd0);
        chk("abort_cout", {63'd0, cout8}, 64'd0);
        chk("abort_ovf", {63'd0, ovf8}, 64'd0);
        repeat (12) @(posedge clk);
        op8("post_rst", 0, 8'h7F, 8'h01, 0, 1, 8'h80, 0, 1); wait_done8("post_rst", 12);

        op16("w16_add", 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0); wait_done16("w16_add", 20);
        op16("w16_sub", 1, 16'h0000, 16'h0001, 0, 16'hFFFF, 0, 0); wait_done16("w16_sub", 20);

        repeat (5) @(posedge clk);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("q16_drained", 64'(q16.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL provide parameter SUB_EN, default 1; 1 enables subtract mode, 0 forces the sub input to be treated as 0.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request; sampled on the rising edge; accepted only when state is IDLE or DONE.
REQ-007 sub  input  1  mode, sampled with start; 0 = a+b+cin, 1 = a-b-cin.
REQ-008 a  input  WIDTH  operand A, sampled with start.
REQ-009 b  input  WIDTH  operand B, sampled with start.
REQ-010 cin  input  1  carry-in (add) or borrow-in (sub), sampled with start.
REQ-011 busy  output  1  high while a bit-serial operation is in progress (RUN state).
REQ-012 done  output  1  one-cycle pulse; sum, cout and ovf are valid in that cycle.
REQ-013 sum  output  WIDTH  result, registered.
REQ-014 cout  output  1  carry-out (add); no-borrow flag, 1 = no borrow (sub).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE; there SHALL be no other reachable state.
REQ-017 IDLE, start=1: SHALL capture a, (sub ? ~b : b), and the initial carry (sub ? ~cin : cin); SHALL clear the bit counter; next state RUN.
REQ-018 RUN: each cycle SHALL add bit[cnt] of both captured operands plus the carry register through one full-adder cell, store the sum bit, update carry, and increment cnt (LSB first).
REQ-019 RUN: when cnt = WIDTH-1, SHALL load sum, cout = final carry, and ovf = (carry into MSB) XOR (carry out of MSB) into the output registers; next state DONE.
REQ-020 DONE: SHALL assert done for exactly one cycle; next state RUN if start=1, else IDLE.
REQ-021 Latency: done SHALL be high in the cycle following the WIDTH-th rising edge after the edge that accepted start; back-to-back throughput SHALL be one result per WIDTH+1 cycles.
REQ-022 start in RUN SHALL be ignored with no effect on the running operation.
REQ-023 sum, cout and ovf SHALL change only on the REQ-019 load or on reset, and SHALL hold between operations.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; the bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-025 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.

Reset
REQ-026 rst=1 SHALL force IDLE and set busy=0, done=0, sum=0, cout=0, ovf=0, carry=0, cnt=0 on the same edge.
REQ-027 rst SHALL take priority over start.
REQ-028 rst asserted in RUN or DONE SHALL abort the operation; no done pulse SHALL follow.

Structure
REQ-029 The FSM state encodings and the WIDTH legality limits SHALL reside in the shared package serial_adder_pkg.
REQ-030 The bit-slice adder SHALL be a separate combinational sub-module, fa_cell, with inputs a, b, ci and outputs s, co, instantiated once.

Verification
REQ-031 WIDTH=8, add: a=8'h5A, b=8'h33, cin=0 -> done 8 cycles after the start edge, sum=8'h8D, cout=0, ovf=1.
REQ-032 WIDTH=8, add: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0.
REQ-033 WIDTH=8, sub: a=8'h10, b=8'h20, cin=0 -> sum=8'hF0, cout=0, ovf=0; then a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
REQ-034 start pulsed again in cycle 3 of RUN -> ignored, result unchanged; start held high during DONE -> next operation accepted with no IDLE cycle.
REQ-035 rst asserted in RUN cycle 4 -> next cycle busy=0, all outputs 0, no done; a following start completes normally.
REQ-036 WIDTH=16: a=16'hFFFF, b=16'h0001, cin=0 -> done 16 cycles after the start edge, sum=16'h0000, cout=1, ovf=0.
